mem_arbiter: RTL and testbench

Arbitrates the single data-RAM port A between the pipeline memory stage (CPU) and a debug/loader host (DBG). The RAM reads synchronously with one cycle of latency. The block grants at most one requester per cycle and applies a bounded-starvation priority scheme. A lock mode gives DBG atomic multi-word sequences. It sits between the memory stage's RAM outputs and the RAM; a denied `cpu_gnt` is the memory-stage stall.

---
 rtl/mem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single data-RAM port A between the CPU memory stage
// and a debug/loader host. A grant is issued in the same cycle as the request.
// Read data comes straight from the RAM one cycle later, qualified by a
// registered rvalid strobe. A small starvation counter hands priority to DBG
// after a run of contended CPU wins. A lock state gives DBG exclusive ownership
// for atomic multi-word sequences.
module mem_arbiter #(
    parameter int ADDR_WIDTH    = 9,
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_CPU_BURST = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    // CPU memory stage
    input  logic                      cpu_req,
    input  logic [DATA_WIDTH/8-1:0]   cpu_we,
    input  logic [ADDR_WIDTH-1:0]     cpu_addr,
    input  logic [DATA_WIDTH-1:0]     cpu_wdata,
    output logic                      cpu_gnt,
    output logic                      cpu_rvalid,
    output logic [DATA_WIDTH-1:0]     cpu_rdata,
    // Debug / loader host
    input  logic                      dbg_req,
    input  logic [DATA_WIDTH/8-1:0]   dbg_we,
    input  logic [ADDR_WIDTH-1:0]     dbg_addr,
    input  logic [DATA_WIDTH-1:0]     dbg_wdata,
    input  logic                      dbg_lock,
    output logic                      dbg_gnt,
    output logic                      dbg_rvalid,
    output logic [DATA_WIDTH-1:0]     dbg_rdata,
    // RAM port A
    output logic [DATA_WIDTH/8-1:0]   ram_we,
    output logic [ADDR_WIDTH-1:0]     ram_addr,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    localparam int BE_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH = $clog2(MAX_CPU_BURST) + 1;

    // Counter value at which the next contended CPU win hands priority to DBG.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MAX_CPU_BURST - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [BE_WIDTH-1:0]  WE_NONE  = {BE_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        CPU_PRI  = 2'b00,   // CPU wins contention
        DBG_PRI  = 2'b01,   // DBG wins contention
        DBG_LOCK = 2'b10    // only DBG may be granted
    } arb_state_e;

    arb_state_e            state_r;
    arb_state_e            state_next_s;
    logic [CNT_WIDTH-1:0]  cnt_r;
    logic [CNT_WIDTH-1:0]  cnt_next_s;

    logic                  cpu_gnt_s;
    logic                  dbg_gnt_s;
    logic                  contended_s;

    logic                  cpu_rvalid_r;
    logic                  dbg_rvalid_r;

    logic [BE_WIDTH-1:0]   ram_we_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [DATA_WIDTH-1:0] ram_wdata_s;

    assign contended_s = cpu_req & dbg_req;

    // Grant decode: the current state picks the winner; reset blocks both requesters.
    always_comb begin
        cpu_gnt_s = 1'b0;
        dbg_gnt_s = 1'b0;
        if (rst) begin
            cpu_gnt_s = 1'b0;
            dbg_gnt_s = 1'b0;
        end else begin
            case (state_r)
                CPU_PRI: begin
                    cpu_gnt_s = cpu_req;
                    dbg_gnt_s = dbg_req & ~cpu_req;
                end
                DBG_PRI: begin
                    dbg_gnt_s = dbg_req;
                    cpu_gnt_s = cpu_req & ~dbg_req;
                end
                DBG_LOCK: begin
                    dbg_gnt_s = dbg_req;
                    cpu_gnt_s = 1'b0;
                end
                default: begin
                    cpu_gnt_s = 1'b0;
                    dbg_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state and starvation-counter logic for the priority FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;

        // Any DBG grant, or DBG going idle, ends a starvation run. Otherwise
        // count contended CPU wins while the CPU holds priority.
        if (dbg_gnt_s || !dbg_req) begin
            cnt_next_s = CNT_ZERO;
        end else if ((state_r == CPU_PRI) && cpu_gnt_s && contended_s) begin
            cnt_next_s = cnt_r + CNT_ONE;
        end else begin
            cnt_next_s = cnt_r;
        end

        case (state_r)
            CPU_PRI: begin
                // Lock is entered only via a real DBG grant, so it can never
                // preempt a CPU grant already issued in this cycle.
                if (dbg_gnt_s && dbg_lock) begin
                    state_next_s = DBG_LOCK;
                end else if (cpu_gnt_s && contended_s && (cnt_r == CNT_LAST)) begin
                    state_next_s = DBG_PRI;
                end else begin
                    state_next_s = CPU_PRI;
                end
            end
            DBG_PRI: begin
                if (dbg_gnt_s && dbg_lock) begin
                    state_next_s = DBG_LOCK;
                end else if (dbg_gnt_s || !dbg_req) begin
                    state_next_s = CPU_PRI;
                end else begin
                    state_next_s = DBG_PRI;
                end
            end
            DBG_LOCK: begin
                // Release is sampled every cycle; a DBG grant in the release
                // cycle still goes through.
                if (!dbg_lock) begin
                    state_next_s = CPU_PRI;
                end else begin
                    state_next_s = DBG_LOCK;
                end
            end
            default: begin
                state_next_s = CPU_PRI;
            end
        endcase

        if (rst) begin
            state_next_s = CPU_PRI;
            cnt_next_s   = CNT_ZERO;
        end else begin
            state_next_s = state_next_s;
            cnt_next_s   = cnt_next_s;
        end
    end

    // FSM state and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= CPU_PRI;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Read-return strobes: a granted access with no byte enables is a read.
    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rvalid_r <= 1'b0;
            dbg_rvalid_r <= 1'b0;
        end else begin
            cpu_rvalid_r <= cpu_gnt_s & ~(|cpu_we);
            dbg_rvalid_r <= dbg_gnt_s & ~(|dbg_we);
        end
    end

    // RAM port mux: the winner drives the port. With no winner the port
    // performs a harmless read of the CPU address, so ram_we is only ever
    // nonzero behind a grant.
    always_comb begin
        ram_we_s    = WE_NONE;
        ram_addr_s  = cpu_addr;
        ram_wdata_s = cpu_wdata;
        if (dbg_gnt_s) begin
            ram_we_s    = dbg_we;
            ram_addr_s  = dbg_addr;
            ram_wdata_s = dbg_wdata;
        end else if (cpu_gnt_s) begin
            ram_we_s    = cpu_we;
            ram_addr_s  = cpu_addr;
            ram_wdata_s = cpu_wdata;
        end else begin
            ram_we_s    = WE_NONE;
            ram_addr_s  = cpu_addr;
            ram_wdata_s = cpu_wdata;
        end
    end

    assign cpu_gnt    = cpu_gnt_s;
    assign dbg_gnt    = dbg_gnt_s;
    assign cpu_rvalid = cpu_rvalid_r;
    assign dbg_rvalid = dbg_rvalid_r;
    // Both requesters see the RAM read bus; rvalid says whose data it is.
    assign cpu_rdata  = ram_rdata;
    assign dbg_rdata  = ram_rdata;
    assign ram_we     = ram_we_s;
    assign ram_addr   = ram_addr_s;
    assign ram_wdata  = ram_wdata_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic. A behavioural arbiter and golden-memory model
// checks every cycle.
module tb_mem_arbiter;

    localparam int AW   = 9;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXB = 4;
    localparam int NWORDS = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0;
    logic [BW-1:0] cpu_we = '0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req = 1'b0;
    logic [BW-1:0] dbg_we = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_wdata = '0;
    logic          dbg_lock = 1'b0;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [BW-1:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;

    mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_CPU_BURST(MAXB)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                            input logic [BW-1:0] we);
        logic [DW-1:0] r;
        r = old;
        for (int b = 0; b < BW; b++) begin
            if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Synchronous RAM: byte-enabled write, one-cycle read latency.
    logic [DW-1:0] ram_mem [NWORDS];
    initial begin
        for (int i = 0; i < NWORDS; i++) ram_mem[i] = '0;
    end
    always @(posedge clk) begin
        ram_mem[ram_addr] <= merge(ram_mem[ram_addr], ram_wdata, ram_we);
        ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model: who has priority, whether DBG holds the lock, the
    // length of the current contended CPU run, and a golden memory image.
    logic [DW-1:0] gold [NWORDS];
    bit            m_locked = 1'b0;
    bit            m_turn   = 1'b0;
    int            m_streak = 0;
    bit            m_cpu_rv = 1'b0;
    bit            m_dbg_rv = 1'b0;
    logic [DW-1:0] m_cpu_data = '0;
    logic [DW-1:0] m_dbg_data = '0;
    initial begin
        for (int i = 0; i < NWORDS; i++) gold[i] = '0;
    end

    // Compare process: checks DUT outputs against the model, then advances it.
    always @(negedge clk) begin : compare
        logic eg_c, eg_d;
        logic [BW-1:0] e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        bit was_cpu_pri;

        if (rst)           begin eg_c = 1'b0;    eg_d = 1'b0; end
        else if (m_locked) begin eg_c = 1'b0;    eg_d = dbg_req; end
        else if (m_turn)   begin eg_d = dbg_req; eg_c = cpu_req && !dbg_req; end
        else               begin eg_c = cpu_req; eg_d = dbg_req && !cpu_req; end

        if (eg_d)      begin e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end
        else if (eg_c) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
        else           begin e_we = '0;     e_addr = cpu_addr; e_wd = cpu_wdata; end

        chk("m_cpu_gnt", cpu_gnt, eg_c);
        chk("m_dbg_gnt", dbg_gnt, eg_d);
        chk("m_ram_we", ram_we, e_we);
        chk("m_ram_addr", ram_addr, e_addr);
        if (e_we != '0) chk("m_ram_wdata", ram_wdata, e_wd);
        if (!rst) begin
            chk("m_cpu_rvalid", cpu_rvalid, m_cpu_rv);
            chk("m_dbg_rvalid", dbg_rvalid, m_dbg_rv);
            if (m_cpu_rv) chk("m_cpu_rdata", cpu_rdata, m_cpu_data);
            if (m_dbg_rv) chk("m_dbg_rdata", dbg_rdata, m_dbg_data);
        end

        if (rst) begin
            m_locked = 1'b0; m_turn = 1'b0; m_streak = 0;
            m_cpu_rv = 1'b0; m_dbg_rv = 1'b0;
        end else begin
            was_cpu_pri = !m_locked && !m_turn;
            m_cpu_rv = eg_c && (cpu_we == '0);
            m_dbg_rv = eg_d && (dbg_we == '0);
            if (eg_c) begin
                m_cpu_data = gold[cpu_addr];
                gold[cpu_addr] = merge(gold[cpu_addr], cpu_wdata, cpu_we);
            end
            if (eg_d) begin
                m_dbg_data = gold[dbg_addr];
                gold[dbg_addr] = merge(gold[dbg_addr], dbg_wdata, dbg_we);
            end
            if (m_locked) begin
                if (!dbg_lock) m_locked = 1'b0;
            end else if (eg_d && dbg_lock) begin
                m_locked = 1'b1; m_turn = 1'b0;
            end else if (m_turn) begin
                if (eg_d || !dbg_req) m_turn = 1'b0;
            end else if (eg_c && dbg_req && m_streak == MAXB - 1) begin
                m_turn = 1'b1;
            end
            if (eg_d || !dbg_req) m_streak = 0;
            else if (was_cpu_pri && eg_c && dbg_req) m_streak = m_streak + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_cpu(input logic r, input logic [BW-1:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic r, input logic [BW-1:0] we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic lk);
        dbg_req = r; dbg_we = we; dbg_addr = a; dbg_wdata = d; dbg_lock = lk;
    endtask

    // Stimulus with hand-computed expectations, then randomized traffic.
    initial begin
        logic [9:0] pat;
        logic [4:0] pat5;
        logic cpu_done, dbg_done;

        // Reset: requests must be ignored while rst is high.
        tick(); tick();
        set_cpu(1'b1, 4'hF, 9'h010, 32'h12345678);
        settle();
        chk("rst_cpu_gnt", cpu_gnt, 1'b0);
        chk("rst_ram_we", ram_we, 4'h0);
        tick();
        rst = 1'b0;
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        settle();
        chk("post_rst_cpu_rvalid", cpu_rvalid, 1'b0);
        chk("post_rst_dbg_rvalid", dbg_rvalid, 1'b0);
        tick();

        // CPU write then read-back.
        set_cpu(1'b1, 4'hF, 9'h010, 32'hDEADBEEF);
        settle(); chk("wr_cpu_gnt", cpu_gnt, 1'b1);
        tick();
        set_cpu(1'b1, 4'h0, 9'h010, 32'h0);
        settle(); chk("rd_cpu_gnt", cpu_gnt, 1'b1); chk("wr_no_rvalid", cpu_rvalid, 1'b0);
        tick();
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        settle();
        chk("rd_cpu_rvalid", cpu_rvalid, 1'b1);
        chk("rd_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        chk("rd_dbg_rvalid", dbg_rvalid, 1'b0);
        tick();

        // Continuous contention: C,C,C,C,D repeating (bit set = DBG wins).
        pat = 10'b10_0001_0000;
        set_cpu(1'b1, 4'h0, 9'h010, 32'h0);
        set_dbg(1'b1, 4'h0, 9'h080, 32'h0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("cont_cpu_gnt", cpu_gnt, !pat[i]);
            chk("cont_dbg_gnt", dbg_gnt, pat[i]);
            if (i > 0) begin
                chk("cont_dbg_rvalid", dbg_rvalid, pat[i-1]);
                chk("cont_cpu_rvalid", cpu_rvalid, !pat[i-1]);
            end
            tick();
        end
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        set_dbg(1'b0, 4'h0, 9'h000, 32'h0, 1'b0);
        settle(); chk("cont_last_dbg_rvalid", dbg_rvalid, 1'b1); chk("cont_last_cpu_rvalid", cpu_rvalid, 1'b0);
        tick();

        // Locked DBG burst: CPU starved until the cycle after the lock drops.
        set_dbg(1'b1, 4'hF, 9'h100, 32'hA0000100, 1'b1);
        settle(); chk("lock_gnt0", dbg_gnt, 1'b1);
        tick();
        set_cpu(1'b1, 4'h0, 9'h101, 32'h0);
        set_dbg(1'b1, 4'hF, 9'h101, 32'hA0000101, 1'b1);
        settle(); chk("lock_cpu_gnt1", cpu_gnt, 1'b0); chk("lock_dbg_gnt1", dbg_gnt, 1'b1);
        tick();
        set_dbg(1'b1, 4'hF, 9'h102, 32'hA0000102, 1'b1);
        settle(); chk("lock_cpu_gnt2", cpu_gnt, 1'b0); chk("lock_dbg_gnt2", dbg_gnt, 1'b1);
        tick();
        set_dbg(1'b0, 4'h0, 9'h000, 32'h0, 1'b0);
        settle(); chk("lock_drop_cpu_gnt", cpu_gnt, 1'b0);
        tick();
        settle(); chk("unlock_cpu_gnt", cpu_gnt, 1'b1);
        tick();
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        settle(); chk("unlock_rvalid", cpu_rvalid, 1'b1); chk("unlock_rdata", cpu_rdata, 32'hA0000101);
        tick();

        // Byte-lane write over an existing word.
        set_cpu(1'b1, 4'hF, 9'h020, 32'hAAAAAAAA); tick();
        set_cpu(1'b1, 4'b0010, 9'h020, 32'h11223344); tick();
        set_cpu(1'b1, 4'h0, 9'h020, 32'h0); tick();
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        settle(); chk("byte_rvalid", cpu_rvalid, 1'b1); chk("byte_rdata", cpu_rdata, 32'hAAAA33AA);
        tick();

        // Reset the cycle after a DBG read grant.
        set_dbg(1'b1, 4'h0, 9'h100, 32'h0, 1'b0);
        settle(); chk("pre_rst_dbg_gnt", dbg_gnt, 1'b1);
        tick();
        rst = 1'b1;
        set_dbg(1'b0, 4'h0, 9'h000, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        settle(); chk("after_rst_dbg_rvalid", dbg_rvalid, 1'b0);
        tick();

        // Part-way through a CPU run, reset must restart the run from zero.
        set_cpu(1'b1, 4'h0, 9'h030, 32'h0);
        set_dbg(1'b1, 4'h0, 9'h031, 32'h0, 1'b0);
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        pat5 = 5'b10000;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("rst_run_cpu_gnt", cpu_gnt, !pat5[i]);
            chk("rst_run_dbg_gnt", dbg_gnt, pat5[i]);
            tick();
        end

        // Idle: no grants, no writes, no rvalid pulses.
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        set_dbg(1'b0, 4'h0, 9'h000, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("idle_ram_we", ram_we, 4'h0);
            chk("idle_gnts", {cpu_gnt, dbg_gnt}, 2'b00);
            chk("idle_rvalids", {cpu_rvalid, dbg_rvalid}, 2'b00);
            tick();
        end

        // Randomized traffic; a requester keeps its fields until granted.
        cpu_done = 1'b0;
        dbg_done = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (!cpu_req || cpu_done) begin
                set_cpu(($urandom % 4) != 0,
                        (($urandom % 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                        9'($urandom_range(496, 511)), $urandom);
            end
            if (!dbg_req || dbg_done) begin
                set_dbg(($urandom % 4) != 0,
                        (($urandom % 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                        9'($urandom_range(496, 511)), $urandom, dbg_lock);
            end
            if (($urandom % 10) == 0) dbg_lock = ~dbg_lock;
            rst = (($urandom % 250) == 0);
            settle();
            cpu_done = cpu_gnt;
            dbg_done = dbg_gnt;
            tick();
        end
        rst = 1'b0;
        set_cpu(1'b0, 4'h0, 9'h000, 32'h0);
        set_dbg(1'b0, 4'h0, 9'h000, 32'h0, 1'b0);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
